// File: rtl/weight_preload_dma.sv
// Weight preload DMA: fetches a run of 128-bit weight words over a burst read channel into the weight buffer.
// Optional XOR checksum of written words is enabled by defining WEIGHT_PRELOAD_CKSUM_EN.
module weight_preload_dma #(
   parameter int                    ADDR_W     = 16,
   parameter int                    BUF_ADDR_W = 16,
   parameter int                    EXT_ADDR_W = 32,
   parameter logic [EXT_ADDR_W-1:0] EXT_BASE   = '0,
   parameter int                    MAX_BURST  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  preload_req,
   input  logic [ADDR_W-1:0]     preload_base,
   input  logic [16:0]           preload_count,
   output logic                  preload_done,
   output logic                  busy,
   output logic                  err_last,
   output logic                  mem_ar_valid,
   input  logic                  mem_ar_ready,
   output logic [EXT_ADDR_W-1:0] mem_ar_addr,
   output logic [7:0]            mem_ar_len,
   input  logic                  mem_r_valid,
   input  logic [127:0]          mem_r_data,
   input  logic                  mem_r_last,
   output logic                  mem_r_ready,
   output logic                  buf_we,
   output logic [BUF_ADDR_W-1:0] buf_waddr,
   output logic [127:0]          buf_wdata,
   output logic [127:0]          cksum
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_FLUSH,
      S_DONE,
      S_HOLD
   } state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic [ADDR_W-1:0]       r_ptr;
   logic [16:0]             r_remaining;
   logic [8:0]              r_len;
   logic [8:0]              r_beat;
   logic                    r_err;
   logic                    r_buf_we;
   logic [BUF_ADDR_W-1:0]   r_buf_waddr;
   logic [127:0]            r_buf_wdata;
   logic                    w_accept;
   logic                    w_beat;
   logic                    w_lastBeat;
   logic [8:0]              w_burstLen;
   logic [EXT_ADDR_W-1:0]   w_arAddr;
   logic [BUF_ADDR_W-1:0]   w_ptrBuf;

   assign w_accept   = (r_state == S_IDLE) && preload_req;
   assign w_beat     = (r_state == S_DATA) && mem_r_valid;
   assign w_lastBeat = (r_beat == (r_len - 9'd1));
   assign w_burstLen = (r_remaining > 17'(MAX_BURST)) ? 9'(MAX_BURST) : r_remaining[8:0];
   assign w_arAddr   = EXT_BASE + (EXT_ADDR_W'(r_ptr) << 4);

   // Buffer address is the word pointer reduced modulo the buffer depth.
   generate
      if (BUF_ADDR_W <= ADDR_W) begin : g_ptrTrunc
         assign w_ptrBuf = r_ptr[BUF_ADDR_W-1:0];
      end else begin : g_ptrExt
         assign w_ptrBuf = {{(BUF_ADDR_W-ADDR_W){1'b0}}, r_ptr};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Only one burst is ever outstanding; the beat counter alone decides where a burst ends.
   always_comb begin
      w_next       = r_state;
      mem_ar_valid = 1'b0;
      mem_ar_addr  = '0;
      mem_ar_len   = '0;
      mem_r_ready  = 1'b0;
      preload_done = 1'b0;
      busy         = (r_state != S_IDLE) && (r_state != S_HOLD);
      case (r_state)
         S_IDLE: begin
            if (preload_req) begin
               w_next = (preload_count == 17'd0) ? S_DONE : S_ADDR;
            end
         end
         S_ADDR: begin
            mem_ar_valid = 1'b1;
            mem_ar_addr  = w_arAddr;
            mem_ar_len   = 8'(w_burstLen - 9'd1);
            if (mem_ar_ready) begin
               w_next = S_DATA;
            end
         end
         S_DATA: begin
            mem_r_ready = 1'b1;
            if (w_beat && w_lastBeat) begin
               w_next = (r_remaining == 17'd1) ? S_FLUSH : S_ADDR;
            end
         end
         S_FLUSH: w_next = S_DONE;
         S_DONE: begin
            preload_done = 1'b1;
            w_next       = S_HOLD;
         end
         S_HOLD: begin
            if (!preload_req) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath: request latch, burst bookkeeping and the registered buffer write port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr       <= '0;
         r_remaining <= '0;
         r_len       <= '0;
         r_beat      <= '0;
         r_err       <= 1'b0;
         r_buf_we    <= 1'b0;
         r_buf_waddr <= '0;
         r_buf_wdata <= '0;
      end else begin
         r_buf_we <= w_beat;
         if (w_accept) begin
            r_ptr       <= preload_base;
            r_remaining <= preload_count;
            r_err       <= 1'b0;
         end
         if ((r_state == S_ADDR) && mem_ar_ready) begin
            r_len  <= w_burstLen;
            r_beat <= '0;
         end
         if (w_beat) begin
            r_buf_waddr <= w_ptrBuf;
            r_buf_wdata <= mem_r_data;
            r_ptr       <= r_ptr + 1'b1;
            r_remaining <= r_remaining - 17'd1;
            r_beat      <= r_beat + 9'd1;
            if (mem_r_last != w_lastBeat) begin
               r_err <= 1'b1;
            end
         end
      end
   end

   assign err_last  = r_err;
   assign buf_we    = r_buf_we;
   assign buf_waddr = r_buf_waddr;
   assign buf_wdata = r_buf_wdata;

`ifdef WEIGHT_PRELOAD_CKSUM_EN
   logic [127:0] r_cksum;

   // Folds in each word as it is written, so the final word lands in the done cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cksum <= '0;
      end else if (w_accept) begin
         r_cksum <= '0;
      end else if (r_buf_we) begin
         r_cksum <= r_cksum ^ r_buf_wdata;
      end
   end

   assign cksum = r_cksum;
`else
   assign cksum = '0;
`endif

endmodule

// File: tb/tb_weight_preload_dma.sv
// Scoreboard bench for weight_preload_dma: stimulus queues expectations, a monitor pops them as the DUT responds.
// Checksum expectations follow WEIGHT_PRELOAD_CKSUM_EN.
module tb_weight_preload_dma;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          preload_req;
   logic [15:0]   preload_base;
   logic [16:0]   preload_count;
   logic          preload_done;
   logic          busy;
   logic          err_last;
   logic          mem_ar_valid;
   logic          mem_ar_ready;
   logic [31:0]   mem_ar_addr;
   logic [7:0]    mem_ar_len;
   logic          mem_r_valid;
   logic [127:0]  mem_r_data;
   logic          mem_r_last;
   logic          mem_r_ready;
   logic          buf_we;
   logic [15:0]   buf_waddr;
   logic [127:0]  buf_wdata;
   logic [127:0]  cksum;

   typedef struct packed {logic [15:0] a; logic [127:0] d;} wr_t;
   typedef struct packed {logic [31:0] addr; logic [7:0] len;} ar_t;
   typedef struct packed {logic err; logic hasData; logic [127:0] ck;} done_t;

   wr_t   wrQ[$];
   ar_t   arQ[$];
   done_t doneQ[$];
   int    weCycQ[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int lastWe = 0;
   int arDelay = 0;
   int rGap = 0;
   int lastAt = -1;

   weight_preload_dma dut (
      .clk(clk), .rst_n(rst_n),
      .preload_req(preload_req), .preload_base(preload_base), .preload_count(preload_count),
      .preload_done(preload_done), .busy(busy), .err_last(err_last),
      .mem_ar_valid(mem_ar_valid), .mem_ar_ready(mem_ar_ready),
      .mem_ar_addr(mem_ar_addr), .mem_ar_len(mem_ar_len),
      .mem_r_valid(mem_r_valid), .mem_r_data(mem_r_data), .mem_r_last(mem_r_last),
      .mem_r_ready(mem_r_ready),
      .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata), .cksum(cksum)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory contents: word i is a single set bit, so XOR checksums are easy to hand-compute.
   function automatic logic [127:0] memWord(input logic [15:0] idx);
      logic [127:0] one;
      one = 128'd1;
      return one << idx[6:0];
   endfunction

   function automatic logic [127:0] ckExp(input logic [127:0] v);
`ifdef WEIGHT_PRELOAD_CKSUM_EN
      return v;
`else
      return 128'd0 & v;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic flagFail(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: got event expected none", name);
   endtask

   // Memory responder: honours AR after arDelay cycles, then returns beats with rGap idle cycles between.
   initial begin : memModel
      int arWait, beatsLeft, beatIdx, burstLen, gapCnt;
      logic [15:0] burstPtr;
      arWait = 0; beatsLeft = 0; beatIdx = 0; burstLen = 0; gapCnt = 0; burstPtr = '0;
      mem_ar_ready = 1'b0; mem_r_valid = 1'b0; mem_r_last = 1'b0; mem_r_data = '0;
      forever begin
         @(negedge clk);
         mem_ar_ready = 1'b0; mem_r_valid = 1'b0; mem_r_last = 1'b0; mem_r_data = '0;
         if (!rst_n) begin
            beatsLeft = 0;
            arWait = 0;
         end else if (beatsLeft == 0) begin
            if (mem_ar_valid) begin
               if (arWait < arDelay) begin
                  arWait++;
                  mem_r_valid = 1'b1;
                  mem_r_last  = 1'b1;
                  mem_r_data  = {4{32'hDEAD_BEEF}};
               end else begin
                  mem_ar_ready = 1'b1;
                  arWait    = 0;
                  burstPtr  = 16'(mem_ar_addr >> 4);
                  burstLen  = int'(mem_ar_len) + 1;
                  beatsLeft = burstLen;
                  beatIdx   = 0;
                  gapCnt    = rGap;
               end
            end
         end else if (mem_r_ready) begin
            if (gapCnt > 0) begin
               gapCnt--;
            end else begin
               mem_r_valid = 1'b1;
               mem_r_data  = memWord(burstPtr + 16'(beatIdx));
               mem_r_last  = (lastAt >= 0) ? (beatIdx == lastAt) : (beatIdx == burstLen - 1);
               weCycQ.push_back(cyc + 1);
               beatIdx++;
               beatsLeft--;
               gapCnt = rGap;
            end
         end
      end
   end

   // Monitor: compares every AR cycle, buffer write and done pulse against the queued expectations.
   initial begin : monitor
      wr_t w;
      done_t d;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            if (mem_ar_valid) begin
               if (arQ.size() == 0) flagFail("ar_unexpected");
               else begin
                  checkOutput("ar_addr", mem_ar_addr, arQ[0].addr);
                  checkOutput("ar_len", mem_ar_len, arQ[0].len);
                  if (mem_ar_ready) void'(arQ.pop_front());
               end
            end
            if (buf_we) begin
               if (wrQ.size() == 0) flagFail("write_unexpected");
               else begin
                  w = wrQ.pop_front();
                  checkOutput("buf_waddr", buf_waddr, w.a);
                  checkOutput("buf_wdata", buf_wdata, w.d);
               end
               if (weCycQ.size() == 0) flagFail("write_no_beat");
               else checkOutput("we_latency", cyc, weCycQ.pop_front());
               lastWe = cyc;
            end
            if (preload_done) begin
               if (doneQ.size() == 0) flagFail("done_unexpected");
               else begin
                  d = doneQ.pop_front();
                  checkOutput("done_err_last", err_last, d.err);
                  checkOutput("done_cksum", cksum, d.ck);
                  checkOutput("done_writes_left", wrQ.size(), 0);
                  if (d.hasData) checkOutput("done_latency", cyc, lastWe + 1);
               end
            end
         end
      end
   end

   task automatic applyStimulus(input logic [15:0] base, input logic [16:0] count, input int arD,
                                input int gap, input int lastA, input logic expErr,
                                input logic [127:0] expCk, input int hold);
      int n;
      logic quiet;
      arDelay = arD; rGap = gap; lastAt = lastA;
      for (int i = 0; i < int'(count); i++)
         wrQ.push_back('{a: base + 16'(i), d: memWord(base + 16'(i))});
      doneQ.push_back('{err: expErr, hasData: (count != 0), ck: expCk});
      @(negedge clk);
      preload_req = 1'b1; preload_base = base; preload_count = count;
      @(negedge clk);
      checkOutput("busy_after_accept", busy, 1'b1);
      checkOutput("err_cleared_on_accept", err_last, 1'b0);
      if (count == 0) checkOutput("zero_done_a1", preload_done, 1'b1);
      else checkOutput("ar_valid_a1", mem_ar_valid, 1'b1);
      n = 0;
      while (!preload_done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (!preload_done) flagFail("done_timeout");
      quiet = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (busy || preload_done || mem_ar_valid || buf_we) quiet = 1'b0;
      end
      checkOutput("quiet_while_req_held", quiet, 1'b1);
      checkOutput("err_sticky", err_last, expErr);
      preload_req = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("queues_drained", wrQ.size() + arQ.size() + doneQ.size() + weCycQ.size(), 0);
   endtask

   initial begin : watchdog
      #2_000_000;
      flagFail("global_timeout");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "[TB] timeout");
   end

   initial begin : stimulus
      rst_n = 1'b0; preload_req = 1'b0; preload_base = '0; preload_count = '0;
      @(negedge clk);
      checkOutput("reset_ctrl", {mem_ar_addr, mem_ar_len, buf_waddr, preload_done, busy, err_last,
                                 mem_ar_valid, mem_r_ready, buf_we}, '0);
      checkOutput("reset_wdata", buf_wdata, '0);
      checkOutput("reset_cksum", cksum, '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] single burst");
      arQ.push_back('{addr: 32'h0000_0100, len: 8'd3});
      applyStimulus(16'h0010, 17'd4, 0, 0, -1, 1'b0, ckExp(128'h000F_0000), 20);

      $display("[TB] multi burst");
      arQ.push_back('{addr: 32'h0000_1000, len: 8'd15});
      arQ.push_back('{addr: 32'h0000_1100, len: 8'd15});
      arQ.push_back('{addr: 32'h0000_1200, len: 8'd7});
      applyStimulus(16'h0100, 17'd40, 0, 0, -1, 1'b0, ckExp(128'hFF_FFFF_FFFF), 1);

      $display("[TB] zero count");
      applyStimulus(16'h0005, 17'd0, 0, 0, -1, 1'b0, 128'd0, 3);

      $display("[TB] stalls and framing error");
      arQ.push_back('{addr: 32'h0000_2000, len: 8'd3});
      applyStimulus(16'h0200, 17'd4, 5, 3, 1, 1'b1, ckExp(128'hF), 2);

      $display("[TB] pointer wrap");
      arQ.push_back('{addr: 32'h000F_FFE0, len: 8'd3});
      applyStimulus(16'hFFFE, 17'd4, 0, 1, -1, 1'b0, ckExp({2'b11, 124'd0, 2'b11}), 1);

      $display("[TB] max burst boundary");
      arQ.push_back('{addr: 32'h0000_3000, len: 8'd15});
      applyStimulus(16'h0300, 17'd16, 0, 0, -1, 1'b0, ckExp(128'hFFFF), 1);
      arQ.push_back('{addr: 32'h0000_4000, len: 8'd15});
      arQ.push_back('{addr: 32'h0000_4100, len: 8'd0});
      applyStimulus(16'h0400, 17'd17, 0, 0, -1, 1'b0, ckExp(128'h1_FFFF), 1);

      $display("[TB] checksum words 1,2,4");
      arQ.push_back('{addr: 32'h0000_0000, len: 8'd2});
      applyStimulus(16'h0000, 17'd3, 0, 0, -1, 1'b0, ckExp(128'h7), 1);

      $display("[TB] reset mid burst");
      arDelay = 0; rGap = 0; lastAt = -1;
      arQ.push_back('{addr: 32'h0000_5000, len: 8'd15});
      arQ.push_back('{addr: 32'h0000_5100, len: 8'd15});
      for (int i = 0; i < 40; i++)
         wrQ.push_back('{a: 16'h0500 + 16'(i), d: memWord(16'h0500 + 16'(i))});
      @(negedge clk);
      preload_req = 1'b1; preload_base = 16'h0500; preload_count = 17'd40;
      repeat (12) @(negedge clk);
      checkOutput("mid_burst_busy", busy, 1'b1);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("reset_mid_ctrl", {mem_ar_addr, mem_ar_len, buf_waddr, preload_done, busy, err_last,
                                     mem_ar_valid, mem_r_ready, buf_we}, '0);
      checkOutput("reset_mid_wdata", buf_wdata, '0);
      wrQ.delete(); arQ.delete(); doneQ.delete(); weCycQ.delete();
      preload_req = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      arQ.push_back('{addr: 32'h0000_0100, len: 8'd3});
      applyStimulus(16'h0010, 17'd4, 0, 0, -1, 1'b0, ckExp(128'h000F_0000), 1);

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/weight_preload_dma.md
# weight_preload_dma

Responder end of the weight preload handshake. It accepts a preload request (word base, word count) from the weight loader / arbiter path and fetches that many 128-bit weight words from external memory over a burst read channel. Each word is written into the weight buffer's write port, and the block pulses `preload_done` once the last word is committed. It sits in top between the external memory interface and the write side of the weight buffer BRAM, whose read side the loader consumes.

## Interface
Parameters:
- `ADDR_W`, 16: width of the request base (weight word index).
- `BUF_ADDR_W`, 16: weight buffer address width.
- `EXT_ADDR_W`, 32: external byte address width.
- `EXT_BASE`, 32'h0000_0000: byte address of weight word 0 in external memory.
- `MAX_BURST`, 16: maximum beats per read burst (1..256).

Ports:
- `clk`  in  1  clock (already decided).
- `rst_n`  in  1  reset: asynchronous, active-low (already decided).
- `preload_req`  in  1  request level; held by requester until `preload_done`.
- `preload_base`  in  ADDR_W  first weight word index.
- `preload_count`  in  17  number of words (0..65536).
- `preload_done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high from accept until the `preload_done` cycle inclusive.
- `err_last`  out  1  sticky `r_last` framing error; cleared on accept.
- `mem_ar_valid`  out  1  burst address valid.
- `mem_ar_ready`  in  1  burst address accepted.
- `mem_ar_addr`  out  EXT_ADDR_W  burst byte address.
- `mem_ar_len`  out  8  beats minus 1.
- `mem_r_valid`  in  1  read beat valid.
- `mem_r_data`  in  128  read beat.
- `mem_r_last`  in  1  last beat of burst.
- `mem_r_ready`  out  1  beat accept.
- `buf_we`  out  1  weight buffer write enable.
- `buf_waddr`  out  BUF_ADDR_W  write address.
- `buf_wdata`  out  128  write data.
- `cksum`  out  128  XOR of words written (only with the macro; tied 0 without).

## Operation
- States: IDLE, ADDR, DATA, FLUSH, DONE, HOLD.
- **IDLE:** when `preload_req`=1, latch base and count. Set `remaining`=count and the word pointer to base. Clear `err_last` (and `cksum`). If count=0, go to DONE; otherwise go to ADDR.
- **ADDR:** drive `mem_ar_valid`=1. `len`=min(`remaining`, MAX_BURST). `mem_ar_addr`=EXT_BASE + pointer·16, truncated to EXT_ADDR_W. `mem_ar_len`=len-1. Address and length stay stable until `mem_ar_ready`, then go to DATA. Only one burst is outstanding at a time.
- **DATA:** `mem_r_ready`=1 continuously; the block never backpressures. On each beat handshake:
  - register a buffer write with `buf_waddr`=pointer[BUF_ADDR_W-1:0] (wraps modulo buffer depth) and `buf_wdata`=`mem_r_data`;
  - increment the pointer and decrement `remaining`.
- **Beat counting:** the beat counter alone ends the burst. `err_last` is set if `mem_r_last` differs from (beat == len-1); `mem_r_last` is otherwise ignored.
- **End of burst:** if `remaining`=0 go to FLUSH; otherwise go to ADDR.
- **FLUSH:** one cycle, during which the final `buf_we` is issued. Then go to DONE.
- **DONE:** `preload_done`=1 for one cycle, then go to HOLD.
- **HOLD:** wait for `preload_req`=0, then go to IDLE. This guarantees one transfer per request level.
- **Arithmetic:** `remaining` is 17 bits. The pointer is ADDR_W bits and wraps.

## Timing
- Reset values: every output is 0 and the state is IDLE. The pointer, `remaining`, `err_last` and `cksum` clear.
- Accept at cycle A; `mem_ar_valid` rises at A+1.
- A beat handshake at cycle T produces `buf_we` at T+1.
- Final beat at T gives the last `buf_we` at T+1 and `preload_done` at T+2. Buffer contents are complete before `done` is seen.
- Count=0: `preload_done` at A+1, with no memory or buffer traffic.
- Back-to-back bursts: next `mem_ar_valid` the cycle after the last beat of the previous burst.
- `mem_r_valid` while not in DATA is ignored (`mem_r_ready`=0).
- `preload_req` held high after done: no re-trigger until it is seen low in HOLD.
- Reset mid-transfer: abort immediately. No `preload_done`, and buffer contents are undefined.

## Configuration
- `WEIGHT_PRELOAD_CKSUM_EN` defined: `cksum` accumulates the XOR of every `buf_wdata` written. It is cleared on accept and is valid from the `preload_done` cycle until the next accept.
- Not defined: no accumulator logic; `cksum` is tied to 0.

## Test plan
- **Single burst:** base=0x0010, count=4, memory returns words W0..W3 with `r_last` on beat 3 -> `ar_addr`=0x100, `ar_len`=3; `buf_we` to 0x10..0x13 with W0..W3; done 2 cycles after beat 3; `err_last`=0.
- **Multi-burst:** count=40, MAX_BURST=16 -> three bursts with len 15,15,7 and addresses base·16, +256, +512; 40 writes; a single `preload_done`.
- **Count=0:** `preload_done` at A+1; `mem_ar_valid` and `buf_we` never assert; `busy` high for exactly 1 cycle.
- **Stalls and framing:** `ar_ready` delayed 5 cycles, then `r_valid` gaps of 3 cycles, with `r_last` on beat 1 of a 4-beat burst -> address stable while stalled; all 4 beats written; `err_last`=1 until the next accept.
- **Handshake hygiene:** `preload_req` held 20 cycles after done -> no second transfer. Reset asserted mid-burst -> all outputs 0 the same cycle; a fresh request afterwards completes normally.
- **Checksum (macro on):** words 0x1, 0x2, 0x4 -> `cksum`=0x7 at done.
